dmem_sized: RTL and testbench

- Parametrised successor of the single-cycle word-only data memory.
- Adds byte/halfword/word access with sign or zero extension, configurable depth and wait-state latency, and a valid/ready request plus response-pulse handshake.
- Sits between the load/store unit of the multicycle or pipelined core and the data RAM array.
- One request is outstanding at a time.

---
 rtl/dmem_sized.sv | 93 +++++++++
 tb/tb_dmem_sized.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_sized.sv
// dmem_sized: byte/half/word data memory with wait states and valid/ready handshake.
// Define DMEM_ALIGN_CHECK_EN to report misaligned or size-11 accesses as errors.
module dmem_sized #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY = 1,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wd,
  output logic              rsp_valid,
  output logic [31:0]       rd,
  output logic              err
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY > 0 ? LATENCY - 1 : 0);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic [IW+1:0] r_addr, w_addr;
  logic [31:0] r_wd, r_rd, w_wd, w_word, w_wdata, w_load;
  logic [1:0] r_size, w_size, w_sz;
  logic r_write, r_unsigned, r_err, w_write, w_unsigned, w_err, w_accept, w_commit;
  logic [3:0] w_be;
  logic [7:0] w_byte;
  logic [15:0] w_half;
  logic w_unused;
  logic [31:0] r_mem [DEPTH_WORDS];
  assign req_ready = r_state == IDLE && !rst;
  assign w_accept = req_valid && req_ready;
  assign rsp_valid = r_state == RESP;
  assign rd = r_rd;
  assign err = r_err;
  assign w_unused = ^addr[ADDR_W-1:IW+2];
  // With zero wait states the commit edge is the acceptance edge, so use live inputs
  assign w_addr = r_state == IDLE ? addr[IW+1:0] : r_addr;
  assign w_wd = r_state == IDLE ? wd : r_wd;
  assign w_size = r_state == IDLE ? req_size : r_size;
  assign w_write = r_state == IDLE ? req_write : r_write;
  assign w_unsigned = r_state == IDLE ? req_unsigned : r_unsigned;
`ifdef DMEM_ALIGN_CHECK_EN
  assign w_err = w_size == 2'b11 || (w_size == 2'b01 && w_addr[0]) || (w_size == 2'b10 && w_addr[1:0] != 2'b00);
  assign w_sz = w_size;
`else
  assign w_err = 1'b0;
  assign w_sz = w_size == 2'b11 ? 2'b10 : w_size;
`endif
  assign w_be = w_sz == 2'b00 ? 4'b0001 << w_addr[1:0] : w_sz == 2'b01 ? (w_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wdata = w_sz == 2'b00 ? {4{w_wd[7:0]}} : w_sz == 2'b01 ? {2{w_wd[15:0]}} : w_wd;
  assign w_word = r_mem[w_addr[IW+1:2]];
  assign w_byte = w_word[8*w_addr[1:0] +: 8];
  assign w_half = w_word[16*w_addr[1] +: 16];
  assign w_load = w_sz == 2'b00 ? {{24{~w_unsigned & w_byte[7]}}, w_byte} :
                  w_sz == 2'b01 ? {{16{~w_unsigned & w_half[15]}}, w_half} : w_word;
  always_comb begin
    w_next = r_state;
    if (rst) w_next = IDLE;
    else if (r_state == IDLE && w_accept) w_next = LATENCY == 0 ? RESP : WAIT;
    else if (r_state == WAIT && r_cnt == 4'd0) w_next = RESP;
    else if (r_state == RESP) w_next = IDLE;
  end
  assign w_commit = w_next == RESP && r_state != RESP;
  always_ff @(posedge clk) begin
    r_state <= w_next;
    if (rst) begin
      r_rd <= '0;
      r_err <= 1'b0;
    end else if (w_commit) begin
      r_rd <= w_write || w_err ? '0 : w_load;
      r_err <= w_err;
    end
    if (w_accept) begin
      r_addr <= addr[IW+1:0];
      r_wd <= wd;
      r_size <= req_size;
      r_write <= req_write;
      r_unsigned <= req_unsigned;
      r_cnt <= CNT_INIT;
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end
  always_ff @(posedge clk)
    if (w_commit && w_write && !w_err)
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_addr[IW+1:2]][8*b +: 8] <= w_wdata[8*b +: 8];
endmodule

// File: tb/tb_dmem_sized.sv
// tb_dmem_sized: directed checks of dmem_sized at LATENCY 1 and a LATENCY 3 instance for reset abort.
module tb_dmem_sized;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, rst3 = 1'b1;
  logic req_valid = 1'b0, v3 = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'b10;
  logic [31:0] addr = '0, wd = '0;
  logic req_ready, rsp_valid, err, ready3, rsp3, err3;
  logic [31:0] rd, rd3;
  int vec = 0, errs = 0;
  logic [31:0] r;
  logic e;
  int c;

  dmem_sized #(.DEPTH_WORDS(256), .LATENCY(1), .ADDR_W(32)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .addr(addr), .wd(wd),
    .rsp_valid(rsp_valid), .rd(rd), .err(err));

  dmem_sized #(.DEPTH_WORDS(256), .LATENCY(3), .ADDR_W(32)) u_dut3 (
    .clk(clk), .rst(rst3), .req_valid(v3), .req_ready(ready3), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .addr(addr), .wd(wd),
    .rsp_valid(rsp3), .rd(rd3), .err(err3));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic xact(input bit d3, input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] dat,
                      output logic [31:0] o_rd, output logic o_err, output int cyc);
    int n;
    @(negedge clk);
    req_write = w; req_size = sz; req_unsigned = u; addr = a; wd = dat;
    if (d3) v3 = 1'b1; else req_valid = 1'b1;
    n = 0;
    while (!(d3 ? ready3 : req_ready) && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0; v3 = 1'b0;
    req_write = ~w; req_size = 2'b11; req_unsigned = ~u; addr = 32'hFFFF_FFFD; wd = 32'h0BAD_0BAD;
    cyc = 1;
    while (!(d3 ? rsp3 : rsp_valid) && cyc < 20) begin @(negedge clk); cyc++; end
    o_rd = d3 ? rd3 : rd;
    o_err = d3 ? err3 : err;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vec++; if (req_ready !== 1'b0) begin errs++; $display("FAIL rst_ready_low: got %b want 0", req_ready); end
    vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rst_rsp_low: got %b want 0", rsp_valid); end
    rst = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL post_rst_ready: got %b want 1", req_ready); end
    vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL post_rst_rsp: got %b want 0", rsp_valid); end
    vec++; if (rd !== 32'h0) begin errs++; $display("FAIL post_rst_rd: got %h want 0", rd); end
    vec++; if (err !== 1'b0) begin errs++; $display("FAIL post_rst_err: got %b want 0", err); end
  endtask

  task automatic test_word;
    xact(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, r, e, c);
    vec++; if (c !== 2) begin errs++; $display("FAIL st_word_lat: got %0d want 2", c); end
    vec++; if (r !== 32'h0 || e !== 1'b0) begin errs++; $display("FAIL st_word_rsp: got rd=%h err=%b want 0/0", r, e); end
    xact(0, 0, 2'b10, 0, 32'h10, 32'h0, r, e, c);
    vec++; if (c !== 2) begin errs++; $display("FAIL ld_word_lat: got %0d want 2", c); end
    vec++; if (r !== 32'hDEADBEEF) begin errs++; $display("FAIL ld_word: got %h want deadbeef", r); end
    vec++; if (e !== 1'b0) begin errs++; $display("FAIL ld_word_err: got %b want 0", e); end
  endtask

  task automatic test_byte;
    xact(0, 1, 2'b10, 0, 32'h10, 32'h11223344, r, e, c);
    xact(0, 1, 2'b00, 0, 32'h13, 32'h12345680, r, e, c);
    vec++; if (r !== 32'h0) begin errs++; $display("FAIL st_byte_rd: got %h want 0", r); end
    xact(0, 0, 2'b10, 0, 32'h10, 32'h0, r, e, c);
    vec++; if (r !== 32'h80223344) begin errs++; $display("FAIL byte_merge: got %h want 80223344", r); end
    xact(0, 0, 2'b00, 0, 32'h13, 32'h0, r, e, c);
    vec++; if (r !== 32'hFFFFFF80) begin errs++; $display("FAIL lb_signed: got %h want ffffff80", r); end
    xact(0, 0, 2'b00, 1, 32'h13, 32'h0, r, e, c);
    vec++; if (r !== 32'h00000080) begin errs++; $display("FAIL lb_unsigned: got %h want 00000080", r); end
    xact(0, 0, 2'b00, 1, 32'h11, 32'h0, r, e, c);
    vec++; if (r !== 32'h00000033) begin errs++; $display("FAIL lb_lane1: got %h want 00000033", r); end
    xact(0, 0, 2'b00, 0, 32'h10, 32'h0, r, e, c);
    vec++; if (r !== 32'h00000044) begin errs++; $display("FAIL lb_lane0_pos: got %h want 00000044", r); end
  endtask

  task automatic test_half;
    xact(0, 1, 2'b10, 0, 32'h20, 32'h01234567, r, e, c);
    xact(0, 1, 2'b01, 0, 32'h22, 32'h5A5AA5A5, r, e, c);
    xact(0, 0, 2'b01, 0, 32'h22, 32'h0, r, e, c);
    vec++; if (r !== 32'hFFFFA5A5) begin errs++; $display("FAIL lh_signed: got %h want ffffa5a5", r); end
    xact(0, 0, 2'b01, 1, 32'h22, 32'h0, r, e, c);
    vec++; if (r !== 32'h0000A5A5) begin errs++; $display("FAIL lh_unsigned: got %h want 0000a5a5", r); end
    xact(0, 0, 2'b10, 0, 32'h20, 32'h0, r, e, c);
    vec++; if (r !== 32'hA5A54567) begin errs++; $display("FAIL half_merge: got %h want a5a54567", r); end
    xact(0, 0, 2'b01, 0, 32'h20, 32'h0, r, e, c);
    vec++; if (r !== 32'h00004567) begin errs++; $display("FAIL lh_low: got %h want 00004567", r); end
  endtask

  task automatic test_align;
    xact(0, 1, 2'b10, 0, 32'h21, 32'hCAFEF00D, r, e, c);
    vec++; if (e !== CHK) begin errs++; $display("FAIL mis_st_err: got %b want %b", e, CHK); end
    vec++; if (r !== 32'h0 || c !== 2) begin errs++; $display("FAIL mis_st_rsp: got rd=%h lat=%0d want 0/2", r, c); end
    xact(0, 0, 2'b10, 0, 32'h20, 32'h0, r, e, c);
    vec++; if (r !== (CHK ? 32'hA5A54567 : 32'hCAFEF00D)) begin errs++; $display("FAIL mis_st_effect: got %h want %h", r, CHK ? 32'hA5A54567 : 32'hCAFEF00D); end
    xact(0, 0, 2'b11, 0, 32'h20, 32'h0, r, e, c);
    vec++; if (e !== CHK || r !== (CHK ? 32'h0 : 32'hCAFEF00D)) begin errs++; $display("FAIL size11: got rd=%h err=%b want %h/%b", r, e, CHK ? 32'h0 : 32'hCAFEF00D, CHK); end
    xact(0, 0, 2'b01, 0, 32'h23, 32'h0, r, e, c);
    vec++; if (e !== CHK || r !== (CHK ? 32'h0 : 32'hFFFFCAFE)) begin errs++; $display("FAIL mis_lh: got rd=%h err=%b want %h/%b", r, e, CHK ? 32'h0 : 32'hFFFFCAFE, CHK); end
  endtask

  task automatic test_wrap;
    xact(0, 1, 2'b10, 0, 32'h400, 32'h5555AAAA, r, e, c);
    xact(0, 0, 2'b10, 0, 32'h000, 32'h0, r, e, c);
    vec++; if (r !== 32'h5555AAAA) begin errs++; $display("FAIL wrap_0x400: got %h want 5555aaaa", r); end
    xact(0, 1, 2'b10, 0, 32'hFFFF_FFF8, 32'h12345678, r, e, c);
    xact(0, 0, 2'b10, 0, 32'h3F8, 32'h0, r, e, c);
    vec++; if (r !== 32'h12345678) begin errs++; $display("FAIL wrap_high: got %h want 12345678", r); end
  endtask

  task automatic test_back_to_back;
    int acc[$];
    int pulses;
    pulses = 0;
    @(negedge clk);
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; addr = 32'h10; req_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (req_ready) acc.push_back(i);
      @(negedge clk);
      if (rsp_valid) begin
        pulses++;
        vec++; if (rd !== 32'h80223344) begin errs++; $display("FAIL b2b_rd: got %h want 80223344", rd); end
      end
    end
    req_valid = 1'b0;
    vec++; if (acc.size() !== 4) begin errs++; $display("FAIL b2b_accepts: got %0d want 4", acc.size()); end
    vec++; if (acc.size() < 2 || acc[1] - acc[0] !== 3) begin errs++; $display("FAIL b2b_gap: got %0d accepts, gap mismatch want 3", acc.size()); end
    vec++; if (pulses !== 4) begin errs++; $display("FAIL b2b_pulses: got %0d want 4", pulses); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_wait;
    int seen;
    seen = 0;
    xact(1, 1, 2'b10, 0, 32'h40, 32'h11111111, r, e, c);
    vec++; if (c !== 4) begin errs++; $display("FAIL l3_lat: got %0d want 4", c); end
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; addr = 32'h40; wd = 32'h22222222; v3 = 1'b1;
    vec++; if (ready3 !== 1'b1) begin errs++; $display("FAIL l3_ready_idle: got %b want 1", ready3); end
    @(negedge clk);
    v3 = 1'b0; rst3 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      vec++; if (ready3 !== 1'b0) begin errs++; $display("FAIL l3_ready_in_rst: got %b want 0", ready3); end
      @(negedge clk);
      if (rsp3) seen++;
    end
    rst3 = 1'b0;
    @(negedge clk);
    vec++; if (ready3 !== 1'b1) begin errs++; $display("FAIL l3_ready_after_rst: got %b want 1", ready3); end
    for (int i = 0; i < 4; i++) begin
      if (rsp3) seen++;
      @(negedge clk);
    end
    vec++; if (seen !== 0) begin errs++; $display("FAIL l3_no_rsp: got %0d pulses want 0", seen); end
    xact(1, 0, 2'b10, 0, 32'h40, 32'h0, r, e, c);
    vec++; if (r !== 32'h11111111) begin errs++; $display("FAIL l3_old_data: got %h want 11111111", r); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_align();
    test_wrap();
    test_back_to_back();
    test_reset_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
